// File: rtl/dircc_processing_mem_msg_reader.sv
// Drains a descriptor-defined run of halfwords from processing memory port s2
// and emits it as one Avalon-ST packet; CSR slave holds descriptor, control and status.
module dircc_processing_mem_msg_reader #(
  parameter int ADDR_W     = 15,
  parameter int MEM_WORDS  = 20480,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  output logic [15:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [15:0]       mem_readdata,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop
);
  // Stream handshake: a beat transfers on any cycle with tx_valid & tx_ready;
  // while tx_valid is high and tx_ready low, data/sop/eop are held unchanged.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] start_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  length_reg;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              irq_en;
  logic              done;
  logic              err;
  logic              inflight;
  logic              sop_pending;

  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;

  logic busy;
  logic go_req;
  logic go_ok;
  logic go_bad;
  logic issue;
  logic fifo_empty;
  logic pop;
  logic last_beat;
  logic done_set;
  logic status_w1c;
  logic unused_wdata;

  assign busy        = (state != ST_IDLE);
  assign go_req      = csr_write && (csr_address == 2'd2) && csr_writedata[0];
  assign go_ok       = go_req && !busy && (length_reg != '0);
  assign go_bad      = go_req && !go_ok;
  assign status_w1c  = csr_write && (csr_address == 2'd3);

  // Entries already buffered plus the one read still returning from memory.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue       = (state == ST_FETCH) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign next_addr   = (rd_addr == ADDR_W'(MEM_WORDS - 1)) ? '0 : rd_addr + ADDR_W'(1);

  assign fifo_empty  = (fifo_count == '0);
  assign pop         = !fifo_empty && tx_ready;
  assign last_beat   = pop && (beat_cnt == LEN_W'(1));
  assign done_set    = (state == ST_DRAIN) && last_beat;

  assign mem_chipselect = issue;
  assign mem_address    = rd_addr;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 2'b11;
  assign mem_writedata  = 16'h0000;
  assign mem_clken      = 1'b1;

  assign tx_valid = !fifo_empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 16'h0000;
  assign tx_sop   = tx_valid && sop_pending;
  assign tx_eop   = tx_valid && (beat_cnt == LEN_W'(1));
  assign irq      = done && irq_en;

  assign unused_wdata = ^csr_writedata[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      rd_addr     <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      sop_pending <= 1'b0;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (pop) begin
        beat_cnt    <= beat_cnt - LEN_W'(1);
        sop_pending <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (go_ok) begin
            rd_addr     <= start_reg;
            issue_cnt   <= length_reg;
            beat_cnt    <= length_reg;
            sop_pending <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            rd_addr   <= next_addr;
            issue_cnt <= issue_cnt - LEN_W'(1);
            if (issue_cnt == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_beat) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data returns exactly one cycle after the request, so inflight marks the write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (inflight) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_ptr] <= mem_readdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_reg    <= '0;
      length_reg   <= '0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (csr_write && !busy && (csr_address == 2'd0)) start_reg  <= csr_writedata[ADDR_W-1:0];
      if (csr_write && !busy && (csr_address == 2'd1)) length_reg <= csr_writedata[LEN_W-1:0];
      if (csr_write && (csr_address == 2'd2))          irq_en     <= csr_writedata[1];

      // A completing packet outranks a simultaneous clear from software.
      if (done_set)                              done <= 1'b1;
      else if (go_ok)                            done <= 1'b0;
      else if (status_w1c && csr_writedata[1])   done <= 1'b0;

      if (go_bad)                                err <= 1'b1;
      else if (status_w1c && csr_writedata[2])   err <= 1'b0;

      if (csr_read) begin
        case (csr_address)
          2'd0:    csr_readdata <= {{(32-ADDR_W){1'b0}}, start_reg};
          2'd1:    csr_readdata <= {{(32-LEN_W){1'b0}}, length_reg};
          2'd2:    csr_readdata <= {30'b0, irq_en, 1'b0};
          default: csr_readdata <= {29'b0, err, done, busy};
        endcase
      end
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(inflight && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_dircc_processing_mem_msg_reader.sv
// Bench for the message reader: memory responder, ready driver, packet-level
// reference queues (addresses and beats) and directed plus random packets.
module tb_dircc_processing_mem_msg_reader;
  localparam int ADDR_W     = 15;
  localparam int MEM_WORDS  = 20480;
  localparam int LEN_W      = 10;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              reset_n;
  logic [1:0]        csr_address;
  logic              csr_read;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;
  logic              irq;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [1:0]        mem_byteenable;
  logic [15:0]       mem_writedata;
  logic              mem_clken;
  logic [15:0]       mem_readdata;
  logic [15:0]       tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_sop;
  logic              tx_eop;

  dircc_processing_mem_msg_reader #(
    .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata), .irq(irq),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop)
  );

  logic [15:0]       mem [MEM_WORDS];
  logic [17:0]       exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int total = 0;
  int bad = 0;
  int issued = 0;
  int accepted = 0;
  int beats_acc = 0;
  int ready_mode = 0;
  int phase = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_beat = '0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder (latency 1) ----------------
  always @(posedge clk) begin
    if (mem_chipselect)
      mem_readdata <= (int'(mem_address) < MEM_WORDS) ? mem[mem_address] : 16'hdead;
  end

  // ---------------- ready driver ----------------
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      addr_q.delete();
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {13'b0, tx_valid, tx_sop, tx_eop, tx_data}, {13'b0, 1'b1, prev_beat});
      if (mem_chipselect) begin
        check("credit", 32'((issued - accepted) < FIFO_DEPTH), 32'd1);
        check("req_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check("addr", 32'(mem_address), 32'(addr_q.pop_front()));
        issued++;
      end
      if (tx_valid && tx_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("beat", 32'({tx_sop, tx_eop, tx_data}), 32'(exp_q.pop_front()));
        accepted++;
        beats_acc++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_beat  = {tx_sop, tx_eop, tx_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    @(posedge clk);
    #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk);
    #1;
    csr_address = a;
    csr_read    = 1'b1;
    @(posedge clk);
    #1;
    csr_read = 1'b0;
    @(negedge clk);
    d = csr_readdata;
  endtask

  task automatic push_pkt(input int start, input int len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (start + i) % MEM_WORDS;
      addr_q.push_back(ADDR_W'(a));
      exp_q.push_back({(i == 0), (i == len - 1), mem[a]});
    end
  endtask

  task automatic run_pkt(input int start, input int len, input logic ien);
    csr_wr(2'd0, 32'(start));
    csr_wr(2'd1, 32'(len));
    push_pkt(start, len);
    csr_wr(2'd2, {30'b0, ien, 1'b1});
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    s = 32'd1;
    for (int k = 0; k < 400; k++) begin
      csr_rd(2'd3, s);
      if (s[0] == 1'b0) break;
    end
    check({tag, "_busy_timeout"}, 32'(s[0]), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size() + addr_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    int b0;
    reset_n = 1'b0;
    csr_address = '0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = '0;
    mem_readdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_readdata", csr_readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_tx", {12'b0, tx_valid, tx_sop, tx_eop, tx_data, 1'b0}, 32'd0);
    csr_rd(2'd3, rd); check("rst_status", rd, 32'd0);
    csr_rd(2'd0, rd); check("rst_start", rd, 32'd0);
    csr_rd(2'd1, rd); check("rst_length", rd, 32'd0);

    // basic 4-beat packet with exact timing from the go edge
    ready_mode = 0;
    csr_wr(2'd0, 32'd100);
    csr_wr(2'd1, 32'd4);
    push_pkt(100, 4);
    csr_wr(2'd2, 32'd3);
    @(negedge clk); check("basic_cs_n1", 32'(mem_chipselect), 32'd1);
                    check("basic_txv_n1", 32'(tx_valid), 32'd0);
    @(negedge clk); check("basic_txv_n2", 32'(tx_valid), 32'd0);
    @(negedge clk); check("basic_sop_n3", {30'b0, tx_valid, tx_sop}, 32'd3);
    @(negedge clk); check("basic_txv_n4", 32'(tx_valid), 32'd1);
    @(negedge clk); check("basic_txv_n5", 32'(tx_valid), 32'd1);
    @(negedge clk); check("basic_eop_n6", {30'b0, tx_valid, tx_eop}, 32'd3);
                    check("basic_irq_n6", 32'(irq), 32'd0);
    @(negedge clk); check("basic_irq_n7", 32'(irq), 32'd1);
                    check("basic_txv_n7", 32'(tx_valid), 32'd0);
    csr_rd(2'd3, rd); check("basic_status", rd, 32'd2);
    check("basic_drained", 32'(exp_q.size()), 32'd0);
    csr_rd(2'd2, rd); check("basic_ctrl", rd, 32'd2);
    csr_wr(2'd2, 32'd0);
    @(negedge clk); check("irq_masked", 32'(irq), 32'd0);
    csr_wr(2'd3, 32'd2);
    csr_rd(2'd3, rd); check("done_w1c", rd, 32'd0);

    // single-beat packet
    run_pkt(int'($urandom_range(0, MEM_WORDS - 1)), 1, 1'b1);
    repeat (3) @(negedge clk);
    check("single_sop_eop", {29'b0, tx_valid, tx_sop, tx_eop}, 32'd7);
    check("single_irq_early", 32'(irq), 32'd0);
    @(negedge clk); check("single_irq", 32'(irq), 32'd1);
    csr_wr(2'd3, 32'd2);

    // backpressure, 1,0,0,1 ready pattern
    ready_mode = 1;
    run_pkt(int'($urandom_range(0, MEM_WORDS - 1)), 16, 1'b0);
    wait_idle("bp");
    csr_wr(2'd3, 32'd2);

    // address wrap
    ready_mode = 0;
    run_pkt(MEM_WORDS - 2, 4, 1'b0);
    wait_idle("wrap");
    csr_wr(2'd3, 32'd2);

    // go with zero length
    csr_wr(2'd1, 32'd0);
    csr_wr(2'd2, 32'd1);
    @(negedge clk); check("len0_cs", 32'(mem_chipselect), 32'd0);
    repeat (3) @(negedge clk);
    check("len0_txv", 32'(tx_valid), 32'd0);
    csr_rd(2'd3, rd); check("len0_status", rd, 32'd4);
    csr_wr(2'd3, 32'd6);
    csr_rd(2'd3, rd); check("err_w1c", rd, 32'd0);

    // go and descriptor writes while busy
    ready_mode = 1;
    run_pkt(500, 16, 1'b0);
    csr_wr(2'd0, 32'd7);
    csr_wr(2'd1, 32'd3);
    csr_wr(2'd2, 32'd1);
    csr_rd(2'd3, rd); check("busy_go_status", rd, 32'd5);
    csr_rd(2'd0, rd); check("busy_start_kept", rd, 32'd500);
    csr_rd(2'd1, rd); check("busy_len_kept", rd, 32'd16);
    wait_idle("busy_go");
    csr_rd(2'd3, rd); check("busy_go_final", rd, 32'd6);
    csr_wr(2'd3, 32'd6);
    csr_rd(2'd3, rd); check("w1c_both", rd, 32'd0);

    // random packets
    for (int n = 0; n < 6; n++) begin
      int st;
      ready_mode = int'($urandom_range(0, 2));
      st = (n == 0) ? MEM_WORDS - 5 : int'($urandom_range(0, MEM_WORDS - 1));
      run_pkt(st, int'($urandom_range(1, 40)), 1'b0);
      wait_idle("rand");
      csr_rd(2'd3, rd); check("rand_done", rd, 32'd2);
      csr_wr(2'd3, 32'd2);
    end

    // reset in the middle of a packet
    ready_mode = 0;
    b0 = beats_acc;
    run_pkt(int'($urandom_range(0, MEM_WORDS - 1)), 8, 1'b1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (beats_acc >= b0 + 3) break;
    end
    check("mid_three_beats", 32'(beats_acc >= b0 + 3), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_txv_dropped", 32'(tx_valid), 32'd0);
    check("mid_irq", 32'(irq), 32'd0);
    csr_rd(2'd3, rd); check("mid_status", rd, 32'd0);
    run_pkt(int'($urandom_range(0, MEM_WORDS - 1)), 5, 1'b0);
    wait_idle("after_rst");
    csr_rd(2'd3, rd); check("after_rst_done", rd, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dircc_processing_mem_msg_reader.md
# dircc_processing_mem_msg_reader

Avalon-MM read master plus Avalon-ST source that drains outgoing messages from a node's dual-port processing memory through its 16-bit second port (s2). The Nios writes a descriptor (start halfword address, length) into a small CSR slave and sets go. The block then fetches the halfwords and emits them as one 16-bit packet toward the node's network transmitter. It raises a maskable done interrupt when the last beat is accepted.

## Interface
Parameters:
- ADDR_W, 15, halfword address width of the memory's 16-bit port
- MEM_WORDS, 20480, halfword depth; fetch address wraps from MEM_WORDS-1 to 0
- LEN_W, 10, length field width; maximum packet is 2^LEN_W-1 halfwords
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- csr_address  in  2  register select
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, valid the cycle after csr_read
- irq  out  1  done & irq_en
- mem_address  out  ADDR_W  halfword address to s2
- mem_chipselect  out  1  read request to s2
- mem_write  out  1  tied 0
- mem_byteenable  out  2  tied 2'b11
- mem_writedata  out  16  tied 0
- mem_clken  out  1  tied 1
- mem_readdata  in  16  s2 read data, fixed latency 1
- tx_data  out  16  stream data
- tx_valid  out  1  stream valid
- tx_ready  in  1  stream ready, ready latency 0
- tx_sop  out  1  first beat of packet
- tx_eop  out  1  last beat of packet

## Operation
- CSR map:
  - 0 START: bits[ADDR_W-1:0], read/write.
  - 1 LENGTH: bits[LEN_W-1:0], read/write.
  - 2 CONTROL: write bit0 = go (self-clearing); bit1 = irq_en (read/write).
  - 3 STATUS: bit0 busy (read-only), bit1 done (W1C), bit2 err (W1C).
- Writes to START and LENGTH while busy are ignored.
- go while busy is ignored and sets err.
- go with LENGTH=0 sets err, no packet, stays IDLE.
- FSM states:
  - IDLE: busy=0. A valid go latches START→rd_addr and LENGTH→issue_cnt and beat_cnt, clears done, and moves to FETCH.
  - FETCH: in each cycle where fifo_count + inflight < FIFO_DEPTH, assert mem_chipselect with mem_address=rd_addr. rd_addr then increments with wrap, and issue_cnt decrements. When issue_cnt reaches 0, move to DRAIN.
  - DRAIN: no requests. Wait until FIFO is empty and the final beat is accepted. Then set done and return to IDLE.
- inflight is a 1-bit register set by a request and cleared when mem_readdata is written into the FIFO the next cycle. The credit rule guarantees the FIFO never overflows; overflow is a design error (assertion).
- Stream beats:
  - A beat is accepted when tx_valid & tx_ready.
  - tx_data, tx_sop and tx_eop hold stable while tx_valid=1 and tx_ready=0.
  - tx_sop=1 on beat index 0; tx_eop=1 when beat_cnt==1; both are 1 for a length-1 packet.
- done is sticky until W1C; irq follows done & irq_en combinationally from registers.

## Timing
- Reset values:
  - csr_readdata=0, irq=0, mem_chipselect=0, mem_address=0.
  - tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0.
  - Registers START, LENGTH, irq_en, done and err are 0; FSM is IDLE; FIFO is empty.
- go write at edge N: FETCH from N+1; first mem_chipselect in cycle N+1. Data is captured at edge N+2, and tx_valid=1 with tx_sop in cycle N+3.
- With tx_ready held high: one beat per cycle, no bubbles. The last beat of an L-halfword packet is accepted in cycle N+2+L, and done/irq are high from cycle N+3+L.
- Backpressure: requests stop within 1 cycle of the FIFO filling. Once tx_ready returns, issue resumes in the same cycle credits free.
- Wrap-around: START=MEM_WORDS-2, L=4 reads addresses 20478, 20479, 0, 1.
- CSR: csr_readdata registered, 1-cycle latency. If a STATUS W1C and a done set occur in the same cycle, the set wins.
- Reset mid-packet (reset_n=0 at any edge):
  - All state returns to reset values at that edge.
  - tx_valid drops the next cycle.
  - The truncated packet carries no eop.
  - done is not set.

## Test plan
- Basic: mem[100..103]=A0,A1,A2,A3; START=100, LENGTH=4, go, tx_ready=1 → beats A0(sop),A1,A2,A3(eop) in consecutive cycles from go+3. Then done=1 at go+7, and irq=1 if irq_en.
- Backpressure: LENGTH=16, tx_ready toggles 1,0,0,1 pattern → all 16 halfwords in order, no loss or duplication. Data stable while stalled, never more than 4 buffered, mem_chipselect low when credits are exhausted.
- Wrap: START=20478, LENGTH=4 → mem_address sequence 20478, 20479, 0, 1; data matches memory.
- Errors: LENGTH=0 plus go → err=1, no tx_valid. go during busy → err=1, and the current packet completes unchanged. Writing 6 to STATUS clears done and err.
- Single beat: LENGTH=1 → one beat with tx_sop=tx_eop=1; done one cycle after acceptance.
- Reset mid-packet: reset_n=0 for 1 cycle after beat 3 of 8 → tx_valid=0 next cycle, busy=0, done=0, and STATUS reads 0. A new go afterwards streams correctly from sop.
